// File: rtl/tmds_gearbox.sv
// tmds_gearbox: serializes per-lane parallel TMDS words into OUT_W-bit chunks behind a one-deep
// holding register, with idle fill, a free-running clock lane and underrun accounting.
module tmds_gearbox #(
    parameter int CHANNELS = 3,
    parameter int WORD_W = 10,
    parameter int OUT_W = 2,
    parameter bit MSB_FIRST = 1'b0,
    parameter bit CLOCK_LANE = 1'b1,
    parameter logic [WORD_W-1:0] CLOCK_PATTERN = 10'b1111100000,
    parameter logic [WORD_W-1:0] IDLE_WORD = 10'b1101010100
) (
    input  logic                         clk_pixel_x5,
    input  logic                         reset,
    input  logic [CHANNELS*WORD_W-1:0]   data_in,
    input  logic                         data_valid,
    output logic                         data_ready,
    output logic                         word_strobe,
    output logic [CHANNELS*OUT_W-1:0]    tmds_out,
    output logic [OUT_W-1:0]             clk_out,
    input  logic                         underrun_clear,
    output logic                         underrun,
    output logic [15:0]                  underrun_count
);
    localparam int R = WORD_W / OUT_W;
    localparam int PW = R > 1 ? $clog2(R) : 1;
    localparam logic [PW-1:0] LAST = PW'(R - 1);

    if (WORD_W % OUT_W != 0 || R < 2) begin : g_bad_ratio
        $error("tmds_gearbox: WORD_W must be a multiple of OUT_W giving at least two chunks");
    end

    typedef enum logic {IDLE, RUN} state_t;

    state_t                       state;
    logic [PW-1:0]                phase;
    logic                         hold_valid;
    logic [CHANNELS*WORD_W-1:0]   hold;
    logic [CHANNELS*WORD_W-1:0]   sh;
    logic [CHANNELS*WORD_W-1:0]   sh_next;
    logic [WORD_W-1:0]            csh;
    logic                         load;
    logic                         xfer;
    logic                         ev;

    // Shifters hold words pre-ordered so the first-transmitted bit always sits at bit 0.
    function automatic logic [WORD_W-1:0] order(input logic [WORD_W-1:0] w);
        logic [WORD_W-1:0] r;
        for (int i = 0; i < WORD_W; i++) r[i] = MSB_FIRST ? w[WORD_W-1-i] : w[i];
        return r;
    endfunction

    assign load        = phase == LAST;
    assign data_ready  = !hold_valid || load;
    assign word_strobe = load;
    assign xfer        = data_valid && data_ready;
    assign ev          = load && !hold_valid && state == RUN;
    assign clk_out     = CLOCK_LANE ? csh[OUT_W-1:0] : '0;

    always_comb begin
        sh_next  = '0;
        tmds_out = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            sh_next[c*WORD_W +: WORD_W] = load ? order(hold_valid ? hold[c*WORD_W +: WORD_W] : IDLE_WORD)
                                               : sh[c*WORD_W +: WORD_W] >> OUT_W;
            tmds_out[c*OUT_W +: OUT_W]  = sh[c*WORD_W +: OUT_W];
        end
    end

    always_ff @(posedge clk_pixel_x5 or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            phase          <= '0;
            hold_valid     <= 1'b0;
            hold           <= '0;
            sh             <= {CHANNELS{order(IDLE_WORD)}};
            csh            <= order(CLOCK_PATTERN);
            underrun       <= 1'b0;
            underrun_count <= '0;
        end else begin
            phase      <= load ? '0 : phase + 1'b1;
            sh         <= sh_next;
            csh        <= load ? order(CLOCK_PATTERN) : csh >> OUT_W;
            hold_valid <= xfer || (hold_valid && !load);
            if (xfer) hold <= data_in;
            if (load && hold_valid) state <= RUN;
            // A clear coinciding with an underrun leaves exactly that one event recorded.
            if (underrun_clear) begin
                underrun       <= ev;
                underrun_count <= {15'd0, ev};
            end else if (ev) begin
                underrun       <= 1'b1;
                underrun_count <= underrun_count != 16'hFFFF ? underrun_count + 16'd1 : underrun_count;
            end
        end
    end
endmodule

// File: tb/tb_tmds_gearbox.sv
// tb_tmds_gearbox: table vectors, hand sequences and random traffic checked against a
// word-level reference model of the gearbox.
module tb_tmds_gearbox;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [29:0] data_in = '0, m_data = '0;
    logic        data_valid = 1'b0, m_valid = 1'b0, uclr = 1'b0;
    logic        data_ready, word_strobe, underrun, m_ready, m_strobe, m_under;
    logic [5:0]  tmds_out, m_tmds;
    logic [1:0]  clk_out, m_clk;
    logic [15:0] ucount, m_count;

    tmds_gearbox dut (
        .clk_pixel_x5(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
        .data_ready(data_ready), .word_strobe(word_strobe), .tmds_out(tmds_out), .clk_out(clk_out),
        .underrun_clear(uclr), .underrun(underrun), .underrun_count(ucount)
    );

    tmds_gearbox #(.MSB_FIRST(1'b1)) dut_m (
        .clk_pixel_x5(clk), .reset(reset), .data_in(m_data), .data_valid(m_valid),
        .data_ready(m_ready), .word_strobe(m_strobe), .tmds_out(m_tmds), .clk_out(m_clk),
        .underrun_clear(1'b0), .underrun(m_under), .underrun_count(m_count)
    );

    typedef struct {
        bit          v;
        logic [9:0]  d0;
        logic [1:0]  tmds0;
        logic [1:0]  clk;
        bit          rdy;
        bit          stb;
        bit          und;
        logic [15:0] cnt;
    } tb_t;

    tb_t tbl[12];
    int passed = 0, total = 0;

    // Reference model: the word shown in the current period, a pending slot and a phase number.
    int          m_ph, m_cnt;
    bit          m_pv, m_run, m_uf;
    logic [29:0] m_pend, m_cur;
    logic [9:0]  idle_w = 10'b1101010100, cp_w = 10'b1111100000;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_ph = 0; m_pv = 1'b0; m_run = 1'b0; m_uf = 1'b0; m_cnt = 0; m_cur = {3{idle_w}};
    endtask

    task automatic check_and_apply(input bit v, input logic [29:0] d, input bit clr);
        logic [26:0] e;
        logic [5:0]  et;
        bit          rdy, ev;
        rdy = !m_pv || m_ph == 4;
        for (int c = 0; c < 3; c++) et[c*2 +: 2] = m_cur[c*10 + 2*m_ph +: 2];
        e = {rdy, m_ph == 4, et, cp_w[2*m_ph +: 2], m_uf, m_cnt[15:0]};
        chk("model", {5'd0, data_ready, word_strobe, tmds_out, clk_out, underrun, ucount}, {5'd0, e});
        data_valid = v; data_in = d; uclr = clr;
        ev = 1'b0;
        if (m_ph == 4) begin
            ev = m_run && !m_pv;
            m_cur = m_pv ? m_pend : {3{idle_w}};
            m_run = m_run || m_pv;
            m_pv = 1'b0;
        end
        if (v && rdy) begin m_pend = d; m_pv = 1'b1; end
        if (clr) begin m_uf = ev; m_cnt = ev ? 1 : 0; end
        else if (ev) begin m_uf = 1'b1; if (m_cnt < 65535) m_cnt++; end
        m_ph = (m_ph + 1) % 5;
    endtask

    task automatic cycle(input bit v, input logic [29:0] d, input bit clr);
        @(negedge clk);
        check_and_apply(v, d, clr);
    endtask

    initial begin
        logic [29:0] a, b;
        bit v;
        tbl[0]  = '{1'b0, 10'h000, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 16'd0};
        tbl[1]  = '{1'b1, 10'h3FF, 2'b01, 2'b00, 1'b1, 1'b0, 1'b0, 16'd0};
        tbl[2]  = '{1'b0, 10'h000, 2'b01, 2'b10, 1'b0, 1'b0, 1'b0, 16'd0};
        tbl[3]  = '{1'b0, 10'h000, 2'b01, 2'b11, 1'b0, 1'b0, 1'b0, 16'd0};
        tbl[4]  = '{1'b0, 10'h000, 2'b11, 2'b11, 1'b1, 1'b1, 1'b0, 16'd0};
        tbl[5]  = '{1'b0, 10'h000, 2'b11, 2'b00, 1'b1, 1'b0, 1'b0, 16'd0};
        tbl[6]  = '{1'b0, 10'h000, 2'b11, 2'b00, 1'b1, 1'b0, 1'b0, 16'd0};
        tbl[7]  = '{1'b0, 10'h000, 2'b11, 2'b10, 1'b1, 1'b0, 1'b0, 16'd0};
        tbl[8]  = '{1'b0, 10'h000, 2'b11, 2'b11, 1'b1, 1'b0, 1'b0, 16'd0};
        tbl[9]  = '{1'b0, 10'h000, 2'b11, 2'b11, 1'b1, 1'b1, 1'b0, 16'd0};
        tbl[10] = '{1'b0, 10'h000, 2'b00, 2'b00, 1'b1, 1'b0, 1'b1, 16'd1};
        tbl[11] = '{1'b0, 10'h000, 2'b01, 2'b00, 1'b1, 1'b0, 1'b1, 16'd1};
        model_reset();
        repeat (2) @(negedge clk);
        chk("reset_out", {5'd0, data_ready, word_strobe, tmds_out, clk_out, underrun, ucount},
            {5'd0, 1'b1, 1'b0, 6'd0, 2'd0, 1'b0, 16'd0});
        chk("reset_msb_idle", {26'd0, m_tmds}, 32'h3F);
        reset = 1'b0;
        // idle pattern, then one all-ones word accepted in phase 1 and a trailing underrun
        for (int i = 0; i < 12; i++) begin
            if (i > 0) @(negedge clk);
            chk($sformatf("tbl%0d", i),
                {9'd0, tmds_out[1:0], clk_out, data_ready, word_strobe, underrun, ucount},
                {9'd0, tbl[i].tmds0, tbl[i].clk, tbl[i].rdy, tbl[i].stb, tbl[i].und, tbl[i].cnt});
            check_and_apply(tbl[i].v, {20'd0, tbl[i].d0}, 1'b0);
        end
        // two words offered from phase 1: second waits until phase 4
        a = 30'($urandom); b = 30'($urandom);
        while (m_ph != 1) cycle(1'b0, '0, 1'b0);
        @(negedge clk); chk("bp_ph1_ready", {31'd0, data_ready}, 32'd1); check_and_apply(1'b1, a, 1'b0);
        @(negedge clk); chk("bp_ph2_ready", {31'd0, data_ready}, 32'd0); check_and_apply(1'b1, b, 1'b0);
        @(negedge clk); chk("bp_ph3_ready", {31'd0, data_ready}, 32'd0); check_and_apply(1'b1, b, 1'b0);
        @(negedge clk); chk("bp_ph4_ready", {31'd0, data_ready}, 32'd1); check_and_apply(1'b1, b, 1'b0);
        @(negedge clk);
        chk("bp_ph0_word", {25'd0, data_ready, tmds_out}, {25'd0, 1'b0, a[21:20], a[11:10], a[1:0]});
        check_and_apply(1'b0, '0, 1'b0);
        // continuous stream with a clear in the middle: no underruns afterwards
        for (int i = 0; i < 10; i++) cycle(1'b1, 30'($urandom), 1'b0);
        cycle(1'b1, 30'($urandom), 1'b1);
        for (int i = 0; i < 25; i++) cycle(1'b1, 30'($urandom), 1'b0);
        @(negedge clk);
        chk("stream_no_underrun", {15'd0, underrun, ucount}, 32'd0);
        check_and_apply(1'b1, 30'($urandom), 1'b0);
        // random traffic alternating dense and sparse stretches, occasional clears
        for (int i = 0; i < 400; i++) begin
            v = ((i / 50) % 2 == 1) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 3) != 0);
            cycle(v, 30'($urandom), $urandom_range(0, 31) == 0);
        end
        // reset in phase 2 of a data word
        while (m_ph != 2) cycle(1'b1, 30'($urandom), 1'b0);
        @(negedge clk);
        #1 reset = 1'b1;
        #1 chk("midword_reset", {5'd0, data_ready, word_strobe, tmds_out, clk_out, underrun, ucount},
            {5'd0, 1'b1, 1'b0, 6'd0, 2'd0, 1'b0, 16'd0});
        data_valid = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        m_valid = 1'b1; m_data = {20'd0, 10'b1000000000};
        check_and_apply(1'b0, '0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            m_valid = 1'b0;
            check_and_apply(1'b0, '0, 1'b0);
        end
        for (int p = 0; p < 5; p++) begin
            @(negedge clk);
            chk($sformatf("msb_first_p%0d", p), {26'd0, m_tmds}, p == 0 ? 32'd1 : 32'd0);
            check_and_apply(1'b0, '0, 1'b0);
        end
        for (int i = 0; i < 10; i++) cycle(1'b0, '0, 1'b0);
        @(negedge clk);
        chk("post_reset_no_underrun", {15'd0, underrun, ucount}, 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
